// File: rtl/l2_cache_responder_if.sv
// L1-facing request/response, main-memory handshake and statistics counters of the L2 responder.
// The slave modport is the cache's view; master is the environment (L1 + memory model).
interface l2_cache_responder_if;
   logic        l1_req;
   logic        l1_write;
   logic [31:0] l1_addr;
   logic [31:0] l1_write_data;
   logic [31:0] l1_read_data;
   logic        l1_ready;
   logic        mm_req;
   logic        mm_write;
   logic [31:0] mm_addr;
   logic [31:0] mm_write_data;
   logic [31:0] mm_read_data;
   logic        mm_ack;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   modport slave (
      input  l1_req, l1_write, l1_addr, l1_write_data, mm_read_data, mm_ack,
      output l1_read_data, l1_ready, mm_req, mm_write, mm_addr, mm_write_data,
             hit_count, miss_count
   );

   modport master (
      output l1_req, l1_write, l1_addr, l1_write_data, mm_read_data, mm_ack,
      input  l1_read_data, l1_ready, mm_req, mm_write, mm_addr, mm_write_data,
             hit_count, miss_count
   );
endinterface

// File: rtl/l2_cache_responder.sv
// Direct-mapped write-back / write-allocate L2 with one-word blocks: serves L1 requests,
// writes back dirty victims and refills from main memory, and counts hits and misses.
module l2_cache_responder #(
   parameter int LINES   = 1024,
   parameter int INDEX_W = $clog2(LINES),
   parameter int TAG_W   = 30 - INDEX_W
) (
   input  logic                  clk,
   input  logic                  reset,
   l2_cache_responder_if.slave   bus
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOOKUP    = 3'd1;
   localparam logic [2:0] S_WRITEBACK = 3'd2;
   localparam logic [2:0] S_REFILL    = 3'd3;
   localparam logic [2:0] S_RESPOND   = 3'd4;

   logic [2:0]         state_r;
   logic               req_write_r;
   logic [TAG_W-1:0]   req_tag_r;
   logic [INDEX_W-1:0] req_index_r;
   logic [31:0]        req_wdata_r;

   logic [31:0]        data_mem_r [LINES];
   logic [TAG_W-1:0]   tag_mem_r  [LINES];
   logic [LINES-1:0]   valid_r;
   logic [LINES-1:0]   dirty_r;

   logic               l1_ready_r;
   logic [31:0]        l1_read_data_r;
   logic               mm_req_r;
   logic               mm_write_r;
   logic [31:0]        mm_addr_r;
   logic [31:0]        mm_write_data_r;
   logic [31:0]        hit_count_r;
   logic [31:0]        miss_count_r;

   logic [31:0]        line_data_s;
   logic [TAG_W-1:0]   line_tag_s;
   logic               hit_s;
   logic               victim_dirty_s;
   logic               unused_addr_s;

   assign bus.l1_ready      = l1_ready_r;
   assign bus.l1_read_data  = l1_read_data_r;
   assign bus.mm_req        = mm_req_r;
   assign bus.mm_write      = mm_write_r;
   assign bus.mm_addr       = mm_addr_r;
   assign bus.mm_write_data = mm_write_data_r;
   assign bus.hit_count     = hit_count_r;
   assign bus.miss_count    = miss_count_r;

   // Byte-offset bits carry no meaning for word blocks.
   assign unused_addr_s = &{1'b0, bus.l1_addr[1:0]};

   // Tag compare against the line selected by the latched request.
   always_comb begin
      line_data_s    = data_mem_r[req_index_r];
      line_tag_s     = tag_mem_r[req_index_r];
      hit_s          = valid_r[req_index_r] && (line_tag_s == req_tag_r);
      victim_dirty_s = valid_r[req_index_r] && dirty_r[req_index_r];
   end

   // Request FSM, line arrays, memory handshake and statistics.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= S_IDLE;
         req_write_r     <= 1'b0;
         req_tag_r       <= {TAG_W{1'b0}};
         req_index_r     <= {INDEX_W{1'b0}};
         req_wdata_r     <= 32'd0;
         valid_r         <= {LINES{1'b0}};
         dirty_r         <= {LINES{1'b0}};
         l1_ready_r      <= 1'b0;
         l1_read_data_r  <= 32'd0;
         mm_req_r        <= 1'b0;
         mm_write_r      <= 1'b0;
         mm_addr_r       <= 32'd0;
         mm_write_data_r <= 32'd0;
         hit_count_r     <= 32'd0;
         miss_count_r    <= 32'd0;
         for (int i = 0; i < LINES; i++) begin
            data_mem_r[i] <= 32'd0;
            tag_mem_r[i]  <= {TAG_W{1'b0}};
         end
      end else begin
         l1_ready_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.l1_req) begin
                  req_write_r <= bus.l1_write;
                  req_tag_r   <= bus.l1_addr[31:INDEX_W+2];
                  req_index_r <= bus.l1_addr[INDEX_W+1:2];
                  req_wdata_r <= bus.l1_write_data;
                  state_r     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit_s) begin
                  hit_count_r <= hit_count_r + 32'd1;
                  if (req_write_r) begin
                     data_mem_r[req_index_r] <= req_wdata_r;
                     dirty_r[req_index_r]    <= 1'b1;
                  end else begin
                     l1_read_data_r <= line_data_s;
                  end
                  l1_ready_r <= 1'b1;
                  state_r    <= S_RESPOND;
               end else begin
                  miss_count_r <= miss_count_r + 32'd1;
                  if (victim_dirty_s) begin
                     mm_req_r        <= 1'b1;
                     mm_write_r      <= 1'b1;
                     mm_addr_r       <= {line_tag_s, req_index_r, 2'b00};
                     mm_write_data_r <= line_data_s;
                     state_r         <= S_WRITEBACK;
                  end else if (req_write_r) begin
                     // Whole block is overwritten, so allocation needs no refill.
                     data_mem_r[req_index_r] <= req_wdata_r;
                     tag_mem_r[req_index_r]  <= req_tag_r;
                     valid_r[req_index_r]    <= 1'b1;
                     dirty_r[req_index_r]    <= 1'b1;
                     l1_ready_r              <= 1'b1;
                     state_r                 <= S_RESPOND;
                  end else begin
                     mm_req_r   <= 1'b1;
                     mm_write_r <= 1'b0;
                     mm_addr_r  <= {req_tag_r, req_index_r, 2'b00};
                     state_r    <= S_REFILL;
                  end
               end
            end
            S_WRITEBACK: begin
               if (bus.mm_ack) begin
                  mm_req_r             <= 1'b0;
                  mm_write_r           <= 1'b0;
                  dirty_r[req_index_r] <= 1'b0;
                  if (req_write_r) begin
                     data_mem_r[req_index_r] <= req_wdata_r;
                     tag_mem_r[req_index_r]  <= req_tag_r;
                     valid_r[req_index_r]    <= 1'b1;
                     dirty_r[req_index_r]    <= 1'b1;
                     l1_ready_r              <= 1'b1;
                     state_r                 <= S_RESPOND;
                  end else begin
                     state_r <= S_REFILL;
                  end
               end
            end
            S_REFILL: begin
               // Entered with mm_req low after a writeback: reissue first, ignore ack meanwhile.
               if (!mm_req_r) begin
                  mm_req_r   <= 1'b1;
                  mm_write_r <= 1'b0;
                  mm_addr_r  <= {req_tag_r, req_index_r, 2'b00};
               end else if (bus.mm_ack) begin
                  mm_req_r                <= 1'b0;
                  data_mem_r[req_index_r] <= bus.mm_read_data;
                  tag_mem_r[req_index_r]  <= req_tag_r;
                  valid_r[req_index_r]    <= 1'b1;
                  dirty_r[req_index_r]    <= 1'b0;
                  l1_read_data_r          <= bus.mm_read_data;
                  l1_ready_r              <= 1'b1;
                  state_r                 <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r  <= S_IDLE;
               mm_req_r <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/l2_cache_responder.md
# l2_cache_responder

Direct-mapped, write-back, write-allocate L2 that acts as the responder for L1 memory-side requests, and as initiator toward main memory. Accepts one 32-bit-block request at a time from L1, answers hits from its own arrays, and on misses writes back a dirty victim before refilling from main memory. Sits between the L1 cache's mem_* port and the main-memory model. Keeps hit and miss counters for the hierarchy statistics.

## Interface
- LINES, 1024, number of lines; power of two; INDEX_W = log2(LINES) = 10
- TAG_W, 20, tag width = 30 − INDEX_W
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- l1_req  in  1  request strobe from L1, sampled only in IDLE
- l1_write  in  1  1 = write, 0 = read; sampled with l1_req
- l1_addr  in  32  byte address; [1:0] ignored, [11:2] index, [31:12] tag
- l1_write_data  in  32  write data; sampled with l1_req
- l1_read_data  out  32  read data; valid while l1_ready = 1; holds otherwise
- l1_ready  out  1  one-cycle completion pulse, reads and writes
- mm_req  out  1  main-memory request, held until mm_ack
- mm_write  out  1  1 = writeback, 0 = refill read
- mm_addr  out  32  block-aligned address ([1:0] = 00)
- mm_write_data  out  32  victim block data
- mm_read_data  in  32  refill data, valid when mm_ack = 1
- mm_ack  in  1  main-memory completion, one cycle
- hit_count  out  32  lookups that hit
- miss_count  out  32  lookups that missed

## Operation
- Per line: 32-bit data, TAG_W tag, valid, dirty. Reset clears all valid, dirty, tags, and data.
- Request registers (write, tag, index, wdata) latch on the IDLE→LOOKUP edge; L1 inputs are don't-care afterwards.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: l1_req=1 → latch, go to LOOKUP. Otherwise stay.
- LOOKUP: hit = valid && tag match.
  - Read hit: l1_read_data ← line data; → RESPOND.
  - Write hit: data ← wdata, dirty ← 1; → RESPOND.
  - Miss with valid && dirty victim: → WRITEBACK.
  - Clean or invalid miss, write: allocate (data ← wdata, tag, valid=1, dirty=1); → RESPOND. The whole block is overwritten, so there is no refill.
  - Clean or invalid miss, read: → REFILL.
- WRITEBACK: mm_req=1, mm_write=1, mm_addr={victim tag, index, 2'b00}, mm_write_data=victim data. On mm_ack: dirty ← 0, then write → allocate as above, → RESPOND; read → REFILL.
- REFILL: mm_req=1, mm_write=0, mm_addr={req tag, index, 2'b00}. On mm_ack: data ← mm_read_data, tag ← req tag, valid=1, dirty=0, l1_read_data ← mm_read_data; → RESPOND.
- RESPOND: l1_ready=1 for exactly this cycle; → IDLE.
- Counters update once per request, in LOOKUP only: hit_count+1 on hit, miss_count+1 on miss. Both wrap modulo 2^32.
- Write data is never forwarded to main memory except through victim writeback.

## Timing
- Reset values: l1_ready=0, l1_read_data=0, mm_req=0, mm_write=0, mm_addr=0, mm_write_data=0, hit_count=0, miss_count=0, state=IDLE.
- All outputs are registered.
- Hit latency: l1_req sampled at edge E0; l1_ready high in the cycle after E1 (2 edges). Next request is accepted at E3 at the earliest.
- Clean read miss: mm_req rises after E1. Ack sampled at edge Ea drops mm_req and enters RESPOND; l1_ready is high after Ea.
- Dirty miss: the writeback handshake, then one edge to reissue mm_req as a refill. mm_req drops for at least one cycle between the two transactions.
- mm_ack outside WRITEBACK/REFILL is ignored. mm_ack in the same cycle that mm_req first rises is accepted.
- l1_req outside IDLE is ignored, not queued. A level-held l1_req in IDLE after RESPOND is accepted as a new request; L1 must deassert once l1_ready is seen.
- Reset mid-operation: immediate return to IDLE and mm_req drops; the pending L1 request is lost with no l1_ready. A late mm_ack is ignored.

## Test plan
- Reset, then read 0x0000_0040 with mm_read_data=0xDEAD_BEEF → one refill at mm_addr 0x0000_0040; l1_ready with 0xDEADBEEF; miss_count=1. A repeat read gives l1_ready 2 edges after the request, hit_count=1, and no mm_req.
- Write 0x1234_5678 to 0x0000_0040, then read it → both hit, read returns 0x12345678, no mm traffic, line dirty.
- Read 0x0000_1040 (same index, new tag) with the line dirty → writeback mm_addr=0x0000_0040, data 0x12345678. Then a refill at 0x0000_1040, then l1_ready.
- Write miss to a clean/invalid line at 0x0000_2080 → no mm_req; l1_ready 2 edges after the request; a following read hits with the written data.
- Hold mm_ack low for 10 cycles during a refill → mm_req, mm_addr, and mm_write stay stable, and l1_req pulses are ignored. Completion occurs on the first mm_ack.
- Assert reset while in REFILL → mm_req=0 and l1_ready=0 the same cycle, counters are 0, and an mm_ack afterwards has no effect.
